// File: rtl/sprite_compositor.sv
// ---------------------------------------------------------------------------
// sprite_compositor
//
// Downstream stage of the palette sprite ROM. Delays the video timing so it
// lines up with the sprite's BROM read latency, composites the sprite's RGB
// over a flat background colour and drives the TMDS/HDMI encoders. The sprite
// position is latched once per frame on new_frame_in and fed back to the
// sprite stage, so a moving sprite never tears mid-frame.
//
// Optional feature macro: SPRITE_CHROMA_KEY_EN
//   defined   -> sprite pixels equal to KEY_COLOR are transparent (show BG)
//   undefined -> every in-window sprite pixel is opaque, KEY_COLOR unused
//
// Ports
//   pixel_clk_in      pixel clock, the only clock
//   rst_in            synchronous active-high reset
//   hcount_in/vcount_in, hsync_in/vsync_in, active_draw_in, new_frame_in
//                     video timing from the timing generator
//   x_req_in/y_req_in requested sprite position, sampled on new_frame_in
//   sprite_x_out/y_out latched position, drives the sprite stage
//   sprite_r/g/b_in   sprite RGB, LATENCY cycles after its hcount
//   red/green/blue_out composited pixel
//   hsync/vsync/active_draw_out timing delayed by LATENCY+1
//   frame_count_out   frames completed at the output, wraps 255->0
// ---------------------------------------------------------------------------
module sprite_compositor #(
    parameter int          WIDTH     = 256,
    parameter int          HEIGHT    = 256,
    parameter int          LATENCY   = 4,
    parameter logic [23:0] BG_COLOR  = 24'h000000,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        active_draw_in,
    input  logic        new_frame_in,
    input  logic [10:0] x_req_in,
    input  logic [9:0]  y_req_in,
    output logic [10:0] sprite_x_out,
    output logic [9:0]  sprite_y_out,
    input  logic [7:0]  sprite_r_in,
    input  logic [7:0]  sprite_g_in,
    input  logic [7:0]  sprite_b_in,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        active_draw_out,
    output logic [7:0]  frame_count_out
);

    // Delay-line word layout
    localparam int TAP_WIN = 4;
    localparam int TAP_HS  = 3;
    localparam int TAP_VS  = 2;
    localparam int TAP_ACT = 1;
    localparam int TAP_NF  = 0;

    logic [10:0] sprite_x_reg;
    logic [9:0]  sprite_y_reg;

    // ---------------- position latch (once per frame) ----------------
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            sprite_x_reg <= '0;
            sprite_y_reg <= '0;
        end else if (new_frame_in) begin
            sprite_x_reg <= x_req_in;
            sprite_y_reg <= y_req_in;
        end
    end

    assign sprite_x_out = sprite_x_reg;
    assign sprite_y_out = sprite_y_reg;

    // ---------------- window test at input time ----------------
    // 12-bit operands so that position + size never wraps around.
    logic [11:0] h_ext, v_ext, x_ext, y_ext;
    logic        in_win;

    assign h_ext = {1'b0, hcount_in};
    assign v_ext = {2'b00, vcount_in};
    assign x_ext = {1'b0, sprite_x_reg};
    assign y_ext = {2'b00, sprite_y_reg};

    assign in_win = (h_ext >= x_ext) && (h_ext < x_ext + 12'(WIDTH)) &&
                    (v_ext >= y_ext) && (v_ext < y_ext + 12'(HEIGHT));

    // ---------------- LATENCY-deep delay line ----------------
    // The last stage holds the timing of the pixel whose sprite RGB is
    // arriving this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_dly
            logic [4:0] stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge pixel_clk_in) begin
                    if (rst_in)
                        stage_reg <= '0;
                    else
                        stage_reg <= {in_win, hsync_in, vsync_in,
                                      active_draw_in, new_frame_in};
                end
            end else begin : g_body
                always_ff @(posedge pixel_clk_in) begin
                    if (rst_in)
                        stage_reg <= '0;
                    else
                        stage_reg <= g_dly[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    logic [4:0] tap;
    assign tap = g_dly[LATENCY-1].stage_reg;

    // ---------------- chroma key ----------------
    logic [23:0] sprite_rgb;
    logic        key;

    assign sprite_rgb = {sprite_r_in, sprite_g_in, sprite_b_in};

`ifdef SPRITE_CHROMA_KEY_EN
    assign key = (sprite_rgb == KEY_COLOR);
`else
    // Keying disabled: KEY_COLOR has no effect on the datapath.
    logic unused_key_color;
    assign unused_key_color = ^KEY_COLOR;
    assign key = 1'b0;
`endif

    // ---------------- registered composite stage ----------------
    // The sprite stage's own outside-window zeroing is misaligned, so the
    // delayed window flag alone decides sprite vs background.
    logic [23:0] rgb_reg;
    logic        hsync_reg, vsync_reg, active_reg;
    logic [7:0]  frame_count_reg;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            rgb_reg         <= '0;
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            active_reg      <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            if (!tap[TAP_ACT])
                rgb_reg <= '0;
            else if (tap[TAP_WIN] && !key)
                rgb_reg <= sprite_rgb;
            else
                rgb_reg <= BG_COLOR;
            hsync_reg  <= tap[TAP_HS];
            vsync_reg  <= tap[TAP_VS];
            active_reg <= tap[TAP_ACT];
            if (tap[TAP_NF])
                frame_count_reg <= frame_count_reg + 8'd1;
        end
    end

    assign red_out         = rgb_reg[23:16];
    assign green_out       = rgb_reg[15:8];
    assign blue_out        = rgb_reg[7:0];
    assign hsync_out       = hsync_reg;
    assign vsync_out       = vsync_reg;
    assign active_draw_out = active_reg;
    assign frame_count_out = frame_count_reg;

endmodule

// File: tb/tb_sprite_compositor.sv
// ---------------------------------------------------------------------------
// tb_sprite_compositor
//
// Self-checking bench for sprite_compositor. Every clock edge the inputs the
// DUT samples are logged; the expected outputs after edge m are derived from
// that log: the pixel sampled L edges earlier, the position latched before
// it, the sprite RGB sampled at edge m, and whether any reset fell in between.
// Directed scenarios add literal expectations; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_sprite_compositor;

    localparam int          L    = 4;
    localparam int          W    = 256;
    localparam int          H    = 256;
    localparam logic [23:0] BG   = 24'h000000;
    localparam logic [23:0] KEY  = 24'hFF00FF;
    localparam int          MAXE = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, hs, vs, act, nf;
    logic [10:0] hcount, xr;
    logic [9:0]  vcount, yr;
    logic [23:0] spr;

    logic [10:0] sprite_x_out;
    logic [9:0]  sprite_y_out;
    logic [7:0]  red_out, green_out, blue_out, frame_count_out;
    logic        hsync_out, vsync_out, active_draw_out;

    sprite_compositor #(
        .WIDTH(W), .HEIGHT(H), .LATENCY(L), .BG_COLOR(BG), .KEY_COLOR(KEY)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst),
        .hcount_in      (hcount),
        .vcount_in      (vcount),
        .hsync_in       (hs),
        .vsync_in       (vs),
        .active_draw_in (act),
        .new_frame_in   (nf),
        .x_req_in       (xr),
        .y_req_in       (yr),
        .sprite_x_out   (sprite_x_out),
        .sprite_y_out   (sprite_y_out),
        .sprite_r_in    (spr[23:16]),
        .sprite_g_in    (spr[15:8]),
        .sprite_b_in    (spr[7:0]),
        .red_out        (red_out),
        .green_out      (green_out),
        .blue_out       (blue_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .active_draw_out(active_draw_out),
        .frame_count_out(frame_count_out)
    );

    typedef struct packed {
        logic        rst;
        logic [10:0] h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        act;
        logic        nf;
        logic [23:0] spr;
    } smp_t;

    smp_t        hist [MAXE];
    logic [10:0] px_h [MAXE];
    logic [9:0]  py_h [MAXE];
    int          e = 0;
    int          fcnt_m = 0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, got, want, e);
        end
    endtask

    // Expected outputs after edge m, from the input log.
    task automatic model_check(input int m);
        bit          valid, win, key;
        smp_t        s;
        int          px, py;
        logic [23:0] rgb_e;
        valid = (m >= L);
        if (valid)
            for (int k = m - L; k <= m; k++)
                if (hist[k].rst) valid = 0;
        s  = valid ? hist[m-L] : '0;
        px = 0;
        py = 0;
        if (valid && (m - L - 1 >= 0)) begin
            px = int'(px_h[m-L-1]);
            py = int'(py_h[m-L-1]);
        end
        win = (int'(s.h) >= px) && (int'(s.h) < px + W) &&
              (int'(s.v) >= py) && (int'(s.v) < py + H);
`ifdef SPRITE_CHROMA_KEY_EN
        key = (hist[m].spr == KEY);
`else
        key = 0;
`endif
        if (!valid || !s.act)  rgb_e = 24'h0;
        else if (win && !key)  rgb_e = hist[m].spr;
        else                   rgb_e = BG;
        if (hist[m].rst)            fcnt_m = 0;
        else if (valid && s.nf)     fcnt_m = (fcnt_m + 1) % 256;

        chk("model_rgb", {red_out, green_out, blue_out}, rgb_e);
        chk("model_sync_act", {hsync_out, vsync_out, active_draw_out},
            {valid && s.hs, valid && s.vs, valid && s.act});
        chk("model_frame_count", frame_count_out, fcnt_m[7:0]);
        chk("model_position", {sprite_x_out, sprite_y_out}, {px_h[m], py_h[m]});
    endtask

    // Log the inputs of this edge, clock once, then check the outputs.
    task automatic tick();
        smp_t s;
        if (e >= MAXE) begin
            $display("FAIL history_overflow: got %0d edges, required < %0d", e, MAXE);
            $fatal(1);
        end
        s.rst = rst; s.h = hcount; s.v = vcount; s.hs = hs; s.vs = vs;
        s.act = act; s.nf = nf; s.spr = spr;
        hist[e] = s;
        if (rst) begin
            px_h[e] = '0; py_h[e] = '0;
        end else if (nf) begin
            px_h[e] = xr; py_h[e] = yr;
        end else if (e > 0) begin
            px_h[e] = px_h[e-1]; py_h[e] = py_h[e-1];
        end else begin
            px_h[e] = '0; py_h[e] = '0;
        end
        @(posedge clk);
        #1;
        model_check(e);
        e++;
    endtask

    logic [23:0] exp_key;
    int          drawn;
    int          lastx, lasty, hv, vv;

    initial begin
        rst = 1'b1; hcount = '0; vcount = '0; hs = 1'b0; vs = 1'b0;
        act = 1'b0; nf = 1'b0; xr = '0; yr = '0; spr = '0;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) begin
            hcount = 11'($urandom_range(0, 1279));
            vcount = 10'($urandom_range(0, 719));
            act = 1'b1; hs = 1'($urandom); vs = 1'($urandom); spr = 24'($urandom);
            tick();
        end

        // Reset held 3 cycles mid-line.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            hcount = 11'($urandom_range(0, 255)); act = 1'b1; hs = 1'b1; vs = 1'b1;
            spr = 24'($urandom);
            tick();
            chk("reset_outputs", {red_out, green_out, blue_out, hsync_out, vsync_out,
                active_draw_out, frame_count_out, sprite_x_out, sprite_y_out}, 64'd0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("active_after_release", active_draw_out, (i == 5));
        end

        // Position latch and first sprite pixel.
        hs = 1'b0; vs = 1'b0; act = 1'b0; spr = '0;
        nf = 1'b1; xr = 11'd100; yr = 10'd50;
        tick();
        nf = 1'b0; hcount = 11'd100; vcount = 10'd50; act = 1'b1;
        tick();
        hcount = 11'd356;
        tick();
        act = 1'b0; hcount = '0;
        tick();
        tick();
        spr = 24'h123456;
        tick();
        chk("sprite_pixel", {red_out, green_out, blue_out}, 24'h123456);
        spr = 24'hABCDEF;
        tick();
        chk("right_edge_bg", {red_out, green_out, blue_out}, BG);
        spr = '0;

        // Position held until the next frame.
        xr = 11'd400;
        tick();
        chk("x_held", sprite_x_out, 11'd100);
        repeat (3) tick();
        chk("x_held_later", sprite_x_out, 11'd100);
        nf = 1'b1;
        tick();
        chk("x_new_frame", sprite_x_out, 11'd400);
        nf = 1'b0;

        // Inactive region in-window: black, syncs delayed.
        hcount = 11'd450; vcount = 10'd60; act = 1'b0; spr = 24'hFFFFFF;
        for (int i = 0; i < 10; i++) begin
            hs = (i == 2); vs = (i == 3);
            tick();
            chk("inactive_rgb", {red_out, green_out, blue_out}, 24'h0);
            chk("hsync_delay", hsync_out, (i == 6));
            chk("vsync_delay", vsync_out, (i == 7));
        end

        // Key-coloured pixel in-window.
`ifdef SPRITE_CHROMA_KEY_EN
        exp_key = BG;
`else
        exp_key = 24'hFF00FF;
`endif
        hs = 1'b0; vs = 1'b0; act = 1'b1; spr = 24'hFF00FF;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 4) chk("key_pixel", {red_out, green_out, blue_out}, exp_key);
        end

        // Frame counter wrap.
        act = 1'b0; spr = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 257; i++) begin
            nf = 1'b1; tick();
            nf = 1'b0; tick();
        end
        repeat (5) tick();
        chk("frame_wrap", frame_count_out, 8'd1);

        // Right-edge clipping.
        xr = 11'd1200; yr = 10'd0; nf = 1'b1;
        tick();
        nf = 1'b0; drawn = 0; vcount = 10'd10; spr = 24'h010203;
        for (int h = 1190; h <= 1300; h++) begin
            hcount = 11'(h); act = (h < 1280);
            tick();
            if ({red_out, green_out, blue_out} == 24'h010203) drawn++;
        end
        act = 1'b0;
        repeat (5) begin
            tick();
            if ({red_out, green_out, blue_out} == 24'h010203) drawn++;
        end
        chk("clip_count", drawn, 80);

        // Randomized traffic.
        lastx = 1200; lasty = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            nf  = ($urandom_range(0, 99) == 0);
            xr  = 11'($urandom_range(0, 1279));
            yr  = 10'($urandom_range(0, 719));
            if (nf && !rst) begin lastx = int'(xr); lasty = int'(yr); end
            if (rst) begin lastx = 0; lasty = 0; end
            if ($urandom_range(0, 1) == 1) begin
                hv = lastx + int'($urandom_range(0, 300)) - 20;
                vv = lasty + int'($urandom_range(0, 300)) - 20;
            end else begin
                hv = int'($urandom_range(0, 2047));
                vv = int'($urandom_range(0, 1023));
            end
            if (hv < 0) hv = 0;
            if (hv > 2047) hv = 2047;
            if (vv < 0) vv = 0;
            if (vv > 1023) vv = 1023;
            hcount = 11'(hv); vcount = 10'(vv);
            act = ($urandom_range(0, 3) != 0);
            hs  = 1'($urandom); vs = 1'($urandom);
            spr = ($urandom_range(0, 7) == 0) ? KEY : 24'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
